// File: rtl/i281_fetch_unit.sv
// i281 instruction fetch sequencer and instruction register; feeds the opcode decoder.
// Optional single-step mode (step input, PAUSE state) enabled by defining I281_FETCH_SINGLE_STEP_EN.
module i281_fetch_unit #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_re,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [7:0]         opcode_out,
  output logic               dec_en,
  output logic [7:0]         imm_out,
  input  logic               exec_done,
  input  logic               branch_take,
  input  logic               halt_req,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
`ifdef I281_FETCH_SINGLE_STEP_EN
  ,
  input  logic               step
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
`ifdef I281_FETCH_SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd6;
`endif

  logic [2:0]         state, state_d;
  logic [PC_W-1:0]    pc, pc_d;
  logic [INSTR_W-1:0] ir, ir_d;
  logic [PC_W-1:0]    imem_addr_d;
  logic               imem_re_d;
  logic               dec_en_d;
  logic               halted_d;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_branch;
`ifdef I281_FETCH_SINGLE_STEP_EN
  logic               step_q;
  logic               step_rise;
`endif

  // Branch target is relative to the following instruction; offset is signed 8-bit.
  assign pc_inc    = pc + PC_W'(1);
  assign pc_branch = pc_inc + PC_W'($signed(ir[7:0]));

`ifdef I281_FETCH_SINGLE_STEP_EN
  assign step_rise = step & ~step_q;
`endif

  assign opcode_out = ir[INSTR_W-1 -: 8];
  assign imm_out    = ir[7:0];
  assign pc_out     = pc;

  // Next-state, datapath and next-output logic; outputs are registered off state_d.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    ir_d    = ir;
    case (state)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          pc_d = branch_take ? pc_branch : pc_inc;
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
`ifdef I281_FETCH_SINGLE_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_FETCH;
`endif
          end
        end
      end
      S_HALT:   state_d = S_HALT;
`ifdef I281_FETCH_SINGLE_STEP_EN
      S_PAUSE:  if (step_rise) state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase

    imem_re_d   = (state_d == S_FETCH);
    dec_en_d    = (state_d == S_DECODE);
    halted_d    = (state_d == S_HALT);
    imem_addr_d = pc_d;
`ifdef I281_FETCH_SINGLE_STEP_EN
    // PAUSE presents an idle bus; only the debug/decoder views keep their values.
    if (state_d == S_PAUSE) imem_addr_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      imem_addr <= '0;
      imem_re   <= 1'b0;
      dec_en    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      imem_addr <= imem_addr_d;
      imem_re   <= imem_re_d;
      dec_en    <= dec_en_d;
      halted    <= halted_d;
    end
  end

`ifdef I281_FETCH_SINGLE_STEP_EN
  // Edge detector so a held step advances only one instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

endmodule

// File: tb/tb_i281_fetch_unit.sv
// Directed self-checking bench for i281_fetch_unit with a synchronous-read code memory model.
// Define I281_FETCH_SINGLE_STEP_EN to also exercise the single-step PAUSE behaviour.
module tb_i281_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  imem_addr;
  logic        imem_re;
  logic [15:0] imem_rdata = '0;
  logic [7:0]  opcode_out;
  logic        dec_en;
  logic [7:0]  imm_out;
  logic        exec_done = 1'b0;
  logic        branch_take = 1'b0;
  logic        halt_req = 1'b0;
  logic [5:0]  pc_out;
  logic        halted;
`ifdef I281_FETCH_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  logic [15:0] mem [64];
  int checks = 0;
  int errors = 0;

  i281_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_rdata(imem_rdata),
    .opcode_out(opcode_out), .dec_en(dec_en), .imm_out(imm_out),
    .exec_done(exec_done), .branch_take(branch_take), .halt_req(halt_req),
    .pc_out(pc_out), .halted(halted)
`ifdef I281_FETCH_SINGLE_STEP_EN
    , .step(step)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_re) imem_rdata <= mem[imem_addr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; exec_done = 1'b0; branch_take = 1'b0; halt_req = 1'b0;
`ifdef I281_FETCH_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Leaves the bench at the negedge inside FETCH of PC=0.
  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Called at a negedge in EXEC; returns in the next FETCH (or HALT).
  task automatic complete_exec(input logic br, input logic hl);
    exec_done = 1'b1; branch_take = br; halt_req = hl;
    tick();
    exec_done = 1'b0; branch_take = 1'b0; halt_req = 1'b0;
`ifdef I281_FETCH_SINGLE_STEP_EN
    if (!hl) begin
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
    end
`endif
  endtask

  // From FETCH, runs one instruction with exec_done in its first EXEC cycle.
  task automatic exec_instr(input logic br, input logic hl);
    tick(); tick(); tick();
    complete_exec(br, hl);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({imem_re, dec_en, halted, imem_addr, pc_out, opcode_out, imm_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: re=%b dec=%b halt=%b addr=%0d pc=%0d op=%h imm=%h, required all 0",
               imem_re, dec_en, halted, imem_addr, pc_out, opcode_out, imm_out);
    end
  endtask

  task automatic test_first_instr();
    mem[0] = 16'hA305; mem[1] = 16'h1100;
    do_reset();
    exec_done = 1'b1;
    start_run();
    checks++;
    if (imem_re !== 1'b1 || imem_addr !== 6'd0 || dec_en !== 1'b0) begin
      errors++; $display("FAIL first_fetch: re=%b addr=%0d dec=%b, required 1/0/0", imem_re, imem_addr, dec_en);
    end
    tick();
    checks++;
    if (imem_re !== 1'b0 || dec_en !== 1'b0) begin
      errors++; $display("FAIL first_load: re=%b dec=%b, required 0/0", imem_re, dec_en);
    end
    tick();
    checks++;
    if (dec_en !== 1'b1 || opcode_out !== 8'hA3 || imm_out !== 8'h05) begin
      errors++; $display("FAIL first_decode: dec=%b op=%h imm=%h, required 1/a3/05", dec_en, opcode_out, imm_out);
    end
    tick();
    checks++;
    if (dec_en !== 1'b0 || pc_out !== 6'd0) begin
      errors++; $display("FAIL first_exec: dec=%b pc=%0d, required 0/0", dec_en, pc_out);
    end
    tick();
    exec_done = 1'b0;
    checks++;
`ifdef I281_FETCH_SINGLE_STEP_EN
    if (pc_out !== 6'd1 || imem_re !== 1'b0) begin
      errors++; $display("FAIL first_next: pc=%0d re=%b, required 1/0", pc_out, imem_re);
    end
`else
    if (pc_out !== 6'd1 || imem_re !== 1'b1 || imem_addr !== 6'd1) begin
      errors++; $display("FAIL first_next: pc=%0d re=%b addr=%0d, required 1/1/1", pc_out, imem_re, imem_addr);
    end
`endif
  endtask

  task automatic test_branch();
    mem[0] = 16'h0109; mem[10] = 16'h20FB; mem[6] = 16'h3038; mem[63] = 16'h407F;
    do_reset();
    start_run();
    exec_instr(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 6'd10 || imem_re !== 1'b1) begin
      errors++; $display("FAIL branch_fwd: addr=%0d re=%b, required 10/1", imem_addr, imem_re);
    end
    exec_instr(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 6'd6) begin
      errors++; $display("FAIL branch_back: addr=%0d, required 6", imem_addr);
    end
    exec_instr(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 6'd63) begin
      errors++; $display("FAIL branch_to_63: addr=%0d, required 63", imem_addr);
    end
    exec_instr(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 6'd63 || pc_out !== 6'd63) begin
      errors++; $display("FAIL branch_wrap_7f: addr=%0d pc=%0d, required 63/63", imem_addr, pc_out);
    end
    exec_instr(1'b0, 1'b0);
    checks++;
    if (imem_addr !== 6'd0 || pc_out !== 6'd0) begin
      errors++; $display("FAIL pc_wrap_inc: addr=%0d pc=%0d, required 0/0", imem_addr, pc_out);
    end
  endtask

  task automatic test_exec_stall();
    int bad = 0;
    mem[0] = 16'h5502;
    do_reset();
    start_run();
    tick(); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_re !== 1'b0 || dec_en !== 1'b0 || pc_out !== 6'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL exec_stall: %0d bad cycles, required 0", bad);
    end
    complete_exec(1'b0, 1'b0);
    checks++;
    if (imem_re !== 1'b1 || imem_addr !== 6'd1) begin
      errors++; $display("FAIL stall_resume: re=%b addr=%0d, required 1/1", imem_re, imem_addr);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    mem[0] = 16'h0104; mem[5] = 16'h6600;
    do_reset();
    start_run();
    exec_instr(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 6'd5) begin
      errors++; $display("FAIL halt_reach5: addr=%0d, required 5", imem_addr);
    end
    exec_instr(1'b0, 1'b1);
    checks++;
    if (halted !== 1'b1 || pc_out !== 6'd6) begin
      errors++; $display("FAIL halt_enter: halted=%b pc=%0d, required 1/6", halted, pc_out);
    end
    for (int i = 0; i < 50; i++) begin
      run = 1'(i % 2); exec_done = 1'(i % 3 == 0); branch_take = 1'b1;
      tick();
      if (imem_re !== 1'b0 || halted !== 1'b1 || pc_out !== 6'd6 || dec_en !== 1'b0) bad++;
    end
    run = 1'b0; exec_done = 1'b0; branch_take = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_absorb: %0d bad cycles, required 0", bad);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || pc_out !== 6'd0) begin
      errors++; $display("FAIL halt_reset: halted=%b pc=%0d, required 0/0", halted, pc_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_re !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: re=%b halted=%b, required 0/0", imem_re, halted);
    end
  endtask

  task automatic test_halt_branch();
    mem[0] = 16'h0109;
    do_reset();
    start_run();
    exec_instr(1'b1, 1'b1);
    checks++;
    if (halted !== 1'b1 || pc_out !== 6'd10) begin
      errors++; $display("FAIL halt_with_branch: halted=%b pc=%0d, required 1/10", halted, pc_out);
    end
  endtask

  task automatic test_reset_in_load();
    mem[0] = 16'h0109; mem[10] = 16'h7777;
    do_reset();
    start_run();
    exec_instr(1'b1, 1'b0);
    tick();
    checks++;
    if (pc_out !== 6'd10 || opcode_out !== 8'h01) begin
      errors++; $display("FAIL load_precond: pc=%0d op=%h, required 10/01", pc_out, opcode_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_re, dec_en, halted, imem_addr, pc_out, opcode_out, imm_out} !== '0) begin
      errors++;
      $display("FAIL async_reset_load: re=%b dec=%b halt=%b addr=%0d pc=%0d op=%h imm=%h, required all 0",
               imem_re, dec_en, halted, imem_addr, pc_out, opcode_out, imm_out);
    end
    tick();
    rst_n = 1'b1;
    start_run();
    checks++;
    if (imem_re !== 1'b1 || imem_addr !== 6'd0) begin
      errors++; $display("FAIL refetch_zero: re=%b addr=%0d, required 1/0", imem_re, imem_addr);
    end
    tick(); tick();
    checks++;
    if (dec_en !== 1'b1 || opcode_out !== 8'h01 || imm_out !== 8'h09) begin
      errors++; $display("FAIL refetch_decode: dec=%b op=%h imm=%h, required 1/01/09", dec_en, opcode_out, imm_out);
    end
  endtask

`ifdef I281_FETCH_SINGLE_STEP_EN
  task automatic test_single_step();
    int bad = 0;
    int fetches = 0;
    mem[0] = 16'h0100; mem[1] = 16'h0200; mem[2] = 16'h0300;
    do_reset();
    start_run();
    tick(); tick(); tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_re !== 1'b0 || imem_addr !== 6'd0) bad++;
    end
    checks++;
    if (bad != 0 || pc_out !== 6'd1 || opcode_out !== 8'h01) begin
      errors++; $display("FAIL pause_hold: bad=%0d pc=%0d op=%h, required 0/1/01", bad, pc_out, opcode_out);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (imem_re !== 1'b1 || imem_addr !== 6'd1) begin
      errors++; $display("FAIL step_pulse: re=%b addr=%0d, required 1/1", imem_re, imem_addr);
    end
    tick(); tick(); tick();
    exec_done = 1'b1;
    tick();
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_re === 1'b1) fetches++;
    end
    step = 1'b0; exec_done = 1'b0;
    checks++;
    if (fetches != 1 || pc_out !== 6'd3) begin
      errors++; $display("FAIL step_held: fetches=%0d pc=%0d, required 1/3", fetches, pc_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_instr();
    test_branch();
    test_exec_stall();
    test_halt();
    test_halt_branch();
    test_reset_in_load();
`ifdef I281_FETCH_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
